// File: rtl/deadtime_gen_pkg.sv
// Shared PWM package: dead-time FSM state encoding and default dead-time width.
package deadtime_gen_pkg;

  localparam int unsigned DT_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DT_HI,
    ST_HI,
    ST_DT_LO,
    ST_LO
  } dt_state_e;

endpackage

// File: rtl/deadtime_gen_if.sv
// Reference-PWM request and gate-drive bundle for one half-bridge leg.
interface deadtime_gen_if
  import deadtime_gen_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEFAULT
) ();

  logic                enable_i;
  logic                pwm_i;
  logic                sync_phase_i;
  logic [DT_WIDTH-1:0] deadtime_i;
  logic                gate_hi_o;
  logic                gate_lo_o;
  logic                dt_active_o;
  logic                pulse_drop_o;

  modport master (
    output enable_i, pwm_i, sync_phase_i, deadtime_i,
    input  gate_hi_o, gate_lo_o, dt_active_o, pulse_drop_o
  );

  modport slave (
    input  enable_i, pwm_i, sync_phase_i, deadtime_i,
    output gate_hi_o, gate_lo_o, dt_active_o, pulse_drop_o
  );

endinterface

// File: rtl/deadtime_gen_dt_counter.sv
// Loadable down-counter that saturates at zero; done flags the last dead-time cycle.
module dt_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  always_comb begin
    done = (count == WIDTH'(1));
  end

endmodule

// File: rtl/deadtime_gen.sv
// Dead-time generator for one PWM leg: turns one reference bit into
// non-overlapping high/low gate drives separated by a programmable gap.
module deadtime_gen
  import deadtime_gen_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  deadtime_gen_if.slave  dt_if
);

  dt_state_e           state;
  dt_state_e           next_state;
  logic [DT_WIDTH-1:0] dt_reg;
  logic                cnt_clear;
  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_done;
  logic                drop;
  logic                pulse_drop_q;

  // A zero request is stored as one so the gap can never vanish.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dt_reg <= '1;
    end else if (dt_if.sync_phase_i) begin
      dt_reg <= (dt_if.deadtime_i == '0) ? DT_WIDTH'(1) : dt_if.deadtime_i;
    end
  end

  dt_counter #(
    .WIDTH (DT_WIDTH)
  ) u_dt_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (dt_reg),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      pulse_drop_q <= 1'b0;
    end else begin
      state        <= next_state;
      pulse_drop_q <= drop;
    end
  end

  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    drop       = 1'b0;
    if (!dt_if.enable_i) begin
      next_state = ST_IDLE;
      cnt_clear  = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          next_state = dt_if.pwm_i ? ST_DT_HI : ST_DT_LO;
          cnt_load   = 1'b1;
        end
        ST_DT_HI: begin
          if (!dt_if.pwm_i) begin
            next_state = ST_DT_LO;
            cnt_load   = 1'b1;
            drop       = 1'b1;
          end else if (cnt_done) begin
            next_state = ST_HI;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_HI: begin
          if (!dt_if.pwm_i) begin
            next_state = ST_DT_LO;
            cnt_load   = 1'b1;
          end
        end
        ST_DT_LO: begin
          if (dt_if.pwm_i) begin
            next_state = ST_DT_HI;
            cnt_load   = 1'b1;
            drop       = 1'b1;
          end else if (cnt_done) begin
            next_state = ST_LO;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_LO: begin
          if (dt_if.pwm_i) begin
            next_state = ST_DT_HI;
            cnt_load   = 1'b1;
          end
        end
        default: begin
          next_state = ST_IDLE;
          cnt_clear  = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    dt_if.gate_hi_o    = (state == ST_HI);
    dt_if.gate_lo_o    = (state == ST_LO);
    dt_if.dt_active_o  = (state == ST_DT_HI) || (state == ST_DT_LO);
    dt_if.pulse_drop_o = pulse_drop_q;
  end

endmodule

// File: doc/deadtime_gen.md
DEADTIME_GEN -- requirements
Module: deadtime_gen

Interface
REQ-001 Parameter DT_WIDTH, default 8: width of the dead-time value in clk_i cycles.
REQ-002 clk_i  input  1  single clock; the same clock that drives Local_counter and Symmetrical_PWM_full.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 enable_i  input  1  leg enable; low forces both gates off.
REQ-005 pwm_i  input  1  reference PWM, one bit of Symmetrical_PWM_full PWM_o; 1 requests the high gate, 0 requests the low gate.
REQ-006 sync_phase_i  input  1  period-boundary strobe from Local_counter; dead-time load point.
REQ-007 deadtime_i  input  DT_WIDTH  requested dead time in clk_i cycles.
REQ-008 gate_hi_o  output  1  high-side gate drive, registered.
REQ-009 gate_lo_o  output  1  low-side gate drive, registered.
REQ-010 dt_active_o  output  1  high while in a dead-time state.
REQ-011 pulse_drop_o  output  1  one-cycle strobe when a reference pulse shorter than the dead time is absorbed.

Function
REQ-012 FSM states: IDLE, DT_HI (waiting to turn the high gate on), HI, DT_LO (waiting to turn the low gate on), LO.
REQ-013 Outputs decode from state: gate_hi_o=1 only in HI; gate_lo_o=1 only in LO; dt_active_o=1 in DT_HI and DT_LO.
REQ-014 Invariant: gate_hi_o and gate_lo_o are never both 1 on any cycle.
REQ-015 dt_reg (DT_WIDTH bits) loads deadtime_i on every edge where sync_phase_i=1 and holds otherwise.
REQ-016 deadtime_i=0 is loaded as 1, so the dead time is never shorter than one cycle.
REQ-017 IDLE with enable_i=1: at the edge go to DT_HI if pwm_i=1, else to DT_LO; counter is loaded with dt_reg.
REQ-018 HI with pwm_i=0: at the edge go to DT_LO with counter=dt_reg, so gate_hi_o falls with 1-cycle latency. LO with pwm_i=1 mirrors this into DT_HI.
REQ-019 In DT_x the counter decrements each edge; at the edge where counter==1 and the request is unchanged, go to state x.
REQ-020 Consequence of REQ-018/019: both gates are low for exactly dt_reg cycles, and the opposite gate asserts dt_reg cycles after the turn-off edge.
REQ-021 Request reverses during DT_x: go to the opposite DT state, reload counter=dt_reg, and strobe pulse_drop_o for one cycle.
REQ-022 sync_phase_i coincides with a counter load: the counter takes the old dt_reg, and the new value applies from the next dead time. A running counter is never modified by a dt_reg update.
REQ-023 enable_i=0 in any state: go to IDLE at that edge, with both gates 0 on the following cycle and the counter cleared. Re-enable follows REQ-017.
REQ-024 Counter width is DT_WIDTH, and it does not wrap: it is loaded with a value of at least 1 and stops at the transition.

Reset
REQ-025 rst_i=1 at an edge: state IDLE, counter 0, dt_reg all-ones (safe maximum), gate_hi_o=0, gate_lo_o=0, dt_active_o=0, pulse_drop_o=0.
REQ-026 rst_i has priority over enable_i and sync_phase_i.
REQ-027 rst_i asserted mid-dead-time or mid-conduction behaves as REQ-025 on the same edge, with no residual gate pulse.

Structure
REQ-028 The FSM state enumeration and the DT_WIDTH default live in the shared PWM package.
REQ-029 One sub-module, dt_counter (loadable down-counter with a done flag), is instantiated once.
REQ-030 The parent instantiates one deadtime_gen per PWM_o bit, between Symmetrical_PWM_full and the IO flops.

Verification
REQ-031 Scenario 1: reset released, sync_phase_i pulse with deadtime_i=5, enable_i=1, pwm_i=1. Required: gate_hi_o rises 5 cycles after the IDLE exit edge; gate_lo_o stays 0.
REQ-032 Scenario 2: dead time 5, pwm_i toggles 1->0. Required: gate_hi_o falls on the next edge, both gates are low for exactly 5 cycles, then gate_lo_o rises.
REQ-033 Scenario 3: dead time 5, a 2-cycle pwm_i low glitch while in HI. Required: gate_lo_o never asserts, pulse_drop_o pulses once, gate_hi_o returns 5 cycles after the reversal.
REQ-034 Scenario 4: deadtime_i=0 loaded on sync_phase_i. Required: dead time of 1 cycle, and no overlap across 5000 cycles of a 1033-count symmetrical PWM.
REQ-035 Scenario 5: enable_i or rst_i dropped mid-DT_LO (counter at 3). Required: both gates 0 next cycle; on re-enable, the full dt_reg is applied before any gate asserts.
REQ-036 Scenario 6: sync_phase_i changes dead time 5->10 on the edge of a pwm_i edge. Required: that dead time is 5 and the next is 10. An assertion checks REQ-014 throughout all scenarios.
